// File: rtl/jstk_pos_integrator.sv
// Multi-axis joystick-to-position integrator. Raw samples are centred,
// deadzoned and scaled, then integrated (relative mode) or mapped directly
// (absolute mode). Results are clamped to [0, POS_MAX] and committed to
// pos_out once per frame, on the vsync rising edge.
module jstk_pos_integrator #(
  parameter int CHANNELS  = 2,
  parameter int DATA_W    = 10,
  parameter int POS_W     = 12,
  parameter int CENTER    = 512,
  parameter int DEADZONE  = 32,
  parameter int SHIFT     = 5,
  parameter int ABS_SHIFT = 0,
  parameter int POS_MAX   = 1023,
  parameter int INIT_POS  = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*DATA_W-1:0]   sample_in,
  input  logic                         sample_valid,
  input  logic                         vsync,
  input  logic                         mode,
  input  logic [CHANNELS-1:0]          load_mask,
  input  logic [CHANNELS*POS_W-1:0]    load_val,
  output logic [CHANNELS*POS_W-1:0]    pos_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = POS_W + 2;
  localparam int AW = DATA_W + ABS_SHIFT;
  localparam int MW = (AW > POS_W) ? AW : POS_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [DATA_W-1:0] CENTER_V  = DATA_W'(CENTER);
  localparam logic [DATA_W:0]   DZ_V      = (DATA_W+1)'(DEADZONE);
  localparam logic [POS_W-1:0]  POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  INIT_V    = POS_W'(INIT_POS);
  localparam logic [CW-1:0]     LAST_CH   = CW'(CHANNELS - 1);

  // Relative step: centre, deadzone, scale (magnitude truncation so the
  // response is symmetric about centre), add to position, clamp.
  function automatic logic [POS_W-1:0] rel_step(input logic [DATA_W-1:0] s,
                                                input logic [POS_W-1:0]  p);
    logic signed [DATA_W:0] d;
    logic        [DATA_W:0] mag;
    logic        [DATA_W:0] m;
    logic signed [SW-1:0]   vel;
    logic signed [SW-1:0]   sum;
    d   = $signed({1'b0, s}) - $signed({1'b0, CENTER_V});
    mag = d[DATA_W] ? (DATA_W+1)'(-d) : (DATA_W+1)'(d);
    if (mag <= DZ_V) begin
      vel = '0;
    end else begin
      m   = (mag - DZ_V) >> SHIFT;
      vel = $signed(SW'(m));
      if (d[DATA_W]) vel = -vel;
    end
    sum = $signed(SW'(p)) + vel;
    if (sum < 0)
      return '0;
    else if (sum > $signed(SW'(POS_MAX_V)))
      return POS_MAX_V;
    else
      return sum[POS_W-1:0];
  endfunction

  // Absolute map: scale the raw sample and saturate at POS_MAX.
  function automatic logic [POS_W-1:0] abs_map(input logic [DATA_W-1:0] s);
    logic [MW-1:0] sh;
    sh = MW'(s) << ABS_SHIFT;
    if (sh > MW'(POS_MAX_V))
      return POS_MAX_V;
    else
      return sh[POS_W-1:0];
  endfunction

  logic [1:0]                   state_q,      state_d;
  logic                         vsync_q,      vsync_d;
  logic [CHANNELS*DATA_W-1:0]   samp_q,       samp_d;
  logic [CHANNELS*DATA_W-1:0]   snap_q,       snap_d;
  logic                         mode_snap_q,  mode_snap_d;
  logic [CW-1:0]                chan_q,       chan_d;
  logic [CHANNELS*POS_W-1:0]    shadow_q,     shadow_d;
  logic [CHANNELS*POS_W-1:0]    pos_q,        pos_d;
  logic [CHANNELS-1:0]          skip_q,       skip_d;
  logic                         frame_done_q, frame_done_d;
  logic                         overrun_q,    overrun_d;

  logic                         tick;
  logic [DATA_W-1:0]            cur_samp;
  logic [POS_W-1:0]             cur_pos;
  logic [POS_W-1:0]             next_val;

  assign tick = vsync & ~vsync_q;

  // Select the channel under calculation and compute its next position.
  always_comb begin
    cur_samp = '0;
    cur_pos  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_q == CW'(i)) begin
        cur_samp = snap_q[i*DATA_W +: DATA_W];
        cur_pos  = pos_q[i*POS_W +: POS_W];
      end
    end
    next_val = mode_snap_q ? abs_map(cur_samp) : rel_step(cur_samp, cur_pos);
  end

  // Frame FSM, sample capture, shadow/commit and preload handling.
  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    samp_d       = samp_q;
    snap_d       = snap_q;
    mode_snap_d  = mode_snap_q;
    chan_d       = chan_q;
    shadow_d     = shadow_q;
    pos_d        = pos_q;
    skip_d       = skip_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;

    if (sample_valid) samp_d = sample_in;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          snap_d      = samp_q;
          mode_snap_d = mode;
          chan_d      = '0;
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (tick) overrun_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (chan_q == CW'(i)) shadow_d[i*POS_W +: POS_W] = next_val;
        end
        if (chan_q == LAST_CH) state_d = S_COMMIT;
        else                   chan_d  = chan_q + CW'(1);
      end
      S_COMMIT: begin
        if (tick) overrun_d = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
          if (!skip_q[i]) pos_d[i*POS_W +: POS_W] = shadow_q[i*POS_W +: POS_W];
        end
        skip_d       = '0;
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Preload overrides any commit on the same edge. Only a load landing
    // mid-calculation needs a skip mark: a load at COMMIT is already final,
    // and a load in IDLE is seen by the next frame through pos_q.
    for (int i = 0; i < CHANNELS; i++) begin
      if (load_mask[i]) begin
        pos_d[i*POS_W +: POS_W] = load_val[i*POS_W +: POS_W];
        if (state_q == S_CALC) skip_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      vsync_q      <= 1'b0;
      samp_q       <= {CHANNELS{CENTER_V}};
      snap_q       <= {CHANNELS{CENTER_V}};
      mode_snap_q  <= 1'b0;
      chan_q       <= '0;
      shadow_q     <= {CHANNELS{INIT_V}};
      pos_q        <= {CHANNELS{INIT_V}};
      skip_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      samp_q       <= samp_d;
      snap_q       <= snap_d;
      mode_snap_q  <= mode_snap_d;
      chan_q       <= chan_d;
      shadow_q     <= shadow_d;
      pos_q        <= pos_d;
      skip_q       <= skip_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pos_out    = pos_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_jstk_pos_integrator.sv
// Directed bench for jstk_pos_integrator (two channels, ABS_SHIFT=1).
module tb_jstk_pos_integrator;

  localparam int CH = 2;
  localparam int DW = 10;
  localparam int PW = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH*DW-1:0]  sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              vsync = 1'b0;
  logic              mode = 1'b0;
  logic [CH-1:0]     load_mask = '0;
  logic [CH*PW-1:0]  load_val = '0;
  logic [CH*PW-1:0]  pos_out;
  logic              busy;
  logic              frame_done;
  logic              overrun;

  int vectors_applied = 0;
  int miscompares = 0;

  jstk_pos_integrator #(
    .CHANNELS(2), .DATA_W(10), .POS_W(12), .CENTER(512), .DEADZONE(32),
    .SHIFT(5), .ABS_SHIFT(1), .POS_MAX(1023), .INIT_POS(512)
  ) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .vsync(vsync), .mode(mode), .load_mask(load_mask), .load_val(load_val),
    .pos_out(pos_out), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors_applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pos_x();
    return int'(pos_out[PW-1:0]);
  endfunction

  function automatic int pos_y();
    return int'(pos_out[2*PW-1:PW]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_samples(input int x, input int y);
    sample_in    = {DW'(y), DW'(x)};
    sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
  endtask

  task automatic do_load(input logic [CH-1:0] m, input int x, input int y);
    load_mask = m;
    load_val  = {PW'(y), PW'(x)};
    cyc();
    load_mask = '0;
  endtask

  // Raise vsync and wait (bounded) for frame_done; report edges and busy cycles.
  task automatic run_frame(output int edges, output int busy_cnt);
    bit got;
    got = 1'b0;
    edges = 0;
    busy_cnt = 0;
    vsync = 1'b1;
    for (int n = 1; n <= 20 && !got; n++) begin
      cyc();
      if (busy) busy_cnt++;
      if (frame_done) begin
        got = 1'b1;
        edges = n;
      end
    end
    if (!got) check_val("frame_timeout", 0, 1);
    vsync = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    int edges, bcnt, fd_cnt, ov_cnt;

    // Reset state
    #12;
    check_val("rst_x", pos_x(), 512);
    check_val("rst_y", pos_y(), 512);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_fd", int'(frame_done), 0);
    check_val("rst_ov", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // Reset asserted mid-CALC
    set_samples(1023, 1023);
    vsync = 1'b1;
    cyc();
    cyc();
    check_val("midcalc_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check_val("midrst_x", pos_x(), 512);
    check_val("midrst_y", pos_y(), 512);
    check_val("midrst_busy", int'(busy), 0);
    vsync = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    fd_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (frame_done) fd_cnt++;
    end
    check_val("midrst_no_fd", fd_cnt, 0);

    // Relative: X full right, Y centred
    set_samples(1023, 512);
    run_frame(edges, bcnt);
    check_val("rel_latency", edges, 4);
    check_val("rel_busy_cycles", bcnt, 3);
    check_val("rel_x", pos_x(), 526);
    check_val("rel_y", pos_y(), 512);

    // Deadzone then full left
    do_load(2'b01, 512, 0);
    check_val("load_x", pos_x(), 512);
    set_samples(540, 512);
    run_frame(edges, bcnt);
    check_val("dz_x", pos_x(), 512);
    set_samples(0, 512);
    run_frame(edges, bcnt);
    check_val("left_x", pos_x(), 497);
    check_val("left_y", pos_y(), 512);

    // Upper clamp over three frames
    do_load(2'b01, 1020, 0);
    set_samples(1023, 512);
    for (int f = 0; f < 3; f++) begin
      run_frame(edges, bcnt);
      check_val($sformatf("clamp_hi_f%0d", f), pos_x(), 1023);
    end
    // Lower clamp
    do_load(2'b01, 5, 0);
    set_samples(0, 512);
    run_frame(edges, bcnt);
    check_val("clamp_lo_x", pos_x(), 0);

    // Absolute mode with ABS_SHIFT=1
    mode = 1'b1;
    set_samples(300, 700);
    run_frame(edges, bcnt);
    check_val("abs_x", pos_x(), 600);
    check_val("abs_y", pos_y(), 1023);
    mode = 1'b0;

    // Load during CALC plus a second vsync rise while busy
    set_samples(1023, 0);
    fd_cnt = 0;
    ov_cnt = 0;
    vsync = 1'b1;
    cyc();                       // tick, snapshot
    cyc();                       // channel 0 computed
    load_mask = 2'b01;
    load_val  = {PW'(0), PW'(100)};
    vsync = 1'b0;
    cyc();                       // load lands, channel 1 computed
    load_mask = '0;
    check_val("inflight_load_x", pos_x(), 100);
    vsync = 1'b1;                // rises while in COMMIT
    cyc();                       // commit
    if (frame_done) fd_cnt++;
    if (overrun) ov_cnt++;
    check_val("inflight_x", pos_x(), 100);
    check_val("inflight_y", pos_y(), 1008);
    for (int n = 0; n < 4; n++) begin
      cyc();
      if (frame_done) fd_cnt++;
      if (overrun) ov_cnt++;
    end
    vsync = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cyc();
      if (frame_done) fd_cnt++;
      if (overrun) ov_cnt++;
    end
    check_val("inflight_fd_count", fd_cnt, 1);
    check_val("inflight_ov_count", ov_cnt, 1);
    check_val("inflight_busy", int'(busy), 0);
    check_val("inflight_x_after", pos_x(), 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
